// File: rtl/debounce_edge_detect_pkg.sv
// Shared types and default constants for the debounce / edge-detect block.
package debounce_edge_detect_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } db_state_t;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_GLITCH_W        = 8;

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Input/output bundle of the debouncer; master drives the raw input, slave is the debouncer.
interface debounce_edge_detect_if #(
  parameter int GLITCH_W = debounce_edge_detect_pkg::DEFAULT_GLITCH_W
);
  logic                raw_i;
  logic                en_i;
  logic                level_o;
  logic                rise_o;
  logic                fall_o;
  logic [GLITCH_W-1:0] glitch_cnt_o;

  modport master (
    output raw_i, en_i,
    input  level_o, rise_o, fall_o, glitch_cnt_o
  );

  modport slave (
    input  raw_i, en_i,
    output level_o, rise_o, fall_o, glitch_cnt_o
  );
endinterface

// File: rtl/debounce_edge_detect_bit_synchronizer.sv
// Plain flop-chain synchronizer for a single asynchronous bit; q_o is the last stage.
module bit_synchronizer
  import debounce_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q[gi] <= 1'b0;
        end else if (gi == 0) begin
          sync_q[gi] <= d_i;
        end else begin
          sync_q[gi] <= sync_q[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronizes a raw input, accepts a new level after DEBOUNCE_CYCLES equal samples,
// emits one-cycle rise/fall pulses and counts aborted level changes.
module debounce_edge_detect
  import debounce_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEFAULT_GLITCH_W
) (
  input logic                    clk,
  input logic                    reset,
  debounce_edge_detect_if.slave  db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  db_state_t           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                level_q;
  logic                rise_q;
  logic                fall_q;
  logic [GLITCH_W-1:0] glitch_q;

  logic                sync_s;
  logic [CNT_W-1:0]    cnt_d;
  logic                accept_d;
  logic [GLITCH_W-1:0] glitch_d;

  bit_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (db.raw_i),
    .q_o   (sync_s)
  );

  assign cnt_d    = cnt_q + CNT_W'(1);
  assign accept_d = (cnt_d == CNT_W'(DEBOUNCE_CYCLES));
  // Saturate instead of wrapping so a noisy line can never look quiet again.
  assign glitch_d = (&glitch_q) ? glitch_q : glitch_q + GLITCH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!db.en_i) begin
        state_q <= level_q ? STABLE_HI : STABLE_LO;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          STABLE_LO: begin
            if (sync_s) begin
              if (DEBOUNCE_CYCLES == 1) begin
                state_q <= STABLE_HI;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                state_q <= CHK_HI;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
          CHK_HI: begin
            if (!sync_s) begin
              state_q  <= STABLE_LO;
              cnt_q    <= '0;
              glitch_q <= glitch_d;
            end else if (accept_d) begin
              state_q <= STABLE_HI;
              cnt_q   <= '0;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          STABLE_HI: begin
            if (!sync_s) begin
              if (DEBOUNCE_CYCLES == 1) begin
                state_q <= STABLE_LO;
                level_q <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                state_q <= CHK_LO;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
          CHK_LO: begin
            if (sync_s) begin
              state_q  <= STABLE_HI;
              cnt_q    <= '0;
              glitch_q <= glitch_d;
            end else if (accept_d) begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= level_q ? STABLE_HI : STABLE_LO;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign db.level_o      = level_q;
  assign db.rise_o       = rise_q;
  assign db.fall_o       = fall_q;
  assign db.glitch_cnt_o = glitch_q;

endmodule
